// File: rtl/pc_control_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pc_control_pkg
// Description : Opcode encoding, default widths and the absolute jump table
//               shared by the program-counter control slice.
// Revision    : 1.0
// ============================================================================
package pc_control_pkg;

    localparam int C_D_DEFAULT   = 10;
    localparam int C_OPW_DEFAULT = 4;

    typedef enum logic [3:0] {
        OP_ALU0    = 4'h0,
        OP_ALU1    = 4'h1,
        OP_ALU2    = 4'h2,
        OP_ALU3    = 4'h3,
        OP_ALU4    = 4'h4,
        OP_ALU5    = 4'h5,
        OP_ALU6    = 4'h6,
        OP_ALU7    = 4'h7,
        OP_MOVTO   = 4'h8,
        OP_MOVFROM = 4'h9,
        OP_ADDI    = 4'hA,
        OP_LD      = 4'hB,
        OP_ST      = 4'hC,
        OP_LDC     = 4'hD,
        OP_BZ      = 4'hE,
        OP_JMP     = 4'hF
    } opcode_t;

    // Absolute jump targets indexed by pc_immed; entry i lands on 8*i.
    localparam logic [C_D_DEFAULT-1:0] c_jump_table [16] = '{
        10'd0,   10'd8,   10'd16,  10'd24,
        10'd32,  10'd40,  10'd48,  10'd56,
        10'd64,  10'd72,  10'd80,  10'd88,
        10'd96,  10'd104, 10'd112, 10'd120
    };

endpackage : pc_control_pkg
`default_nettype wire

// File: rtl/pc_control_if.sv
`default_nettype none
// ============================================================================
// Module      : pc_control_if
// Description : Instruction/datapath bundle between the controller and the
//               rest of the core.
// Revision    : 1.0
// ============================================================================
interface pc_control_if #(
    parameter int D   = 10,
    parameter int OPW = 4
);
    logic [8:0]     instr;
    logic [7:0]     datA;
    logic [7:0]     datB;
    logic [7:0]     mem_out;
    logic [7:0]     mem_lut_out;
    logic [7:0]     alu_rslt;
    logic [D-1:0]   prog_ctr;
    logic           Branch;
    logic           MemtoReg;
    logic           MemWrite;
    logic           ALUSrc;
    logic           RegWrite;
    logic [3:0]     regA;
    logic [3:0]     regB;
    logic [3:0]     wr_addr;
    logic [7:0]     dat_in;
    logic [7:0]     mem_in;
    logic [7:0]     mem_addr;
    logic [4:0]     immed;
    logic [3:0]     pc_immed;
    logic [OPW-1:0] ALUOp;

    modport master (
        output instr, datA, datB, mem_out, mem_lut_out, alu_rslt,
        input  prog_ctr, Branch, MemtoReg, MemWrite, ALUSrc, RegWrite,
        input  regA, regB, wr_addr, dat_in, mem_in, mem_addr,
        input  immed, pc_immed, ALUOp
    );

    modport slave (
        input  instr, datA, datB, mem_out, mem_lut_out, alu_rslt,
        output prog_ctr, Branch, MemtoReg, MemWrite, ALUSrc, RegWrite,
        output regA, regB, wr_addr, dat_in, mem_in, mem_addr,
        output immed, pc_immed, ALUOp
    );

endinterface : pc_control_if
`default_nettype wire

// File: rtl/pc_reg.sv
`default_nettype none
// ============================================================================
// Module      : pc_reg
// Description : Program counter register with reset / absolute / relative /
//               increment next-PC selection (reset has top priority).
// Revision    : 1.0
// ============================================================================
module pc_reg #(
    parameter int D = 10
) (
    input  wire logic         clk,
    input  wire logic         reset,
    input  wire logic         branch,
    input  wire logic [D-1:0] target,
    input  wire logic         rel_jump,
    input  wire logic [D-1:0] rel_offset,
    output logic [D-1:0]      prog_ctr
);

    logic [D-1:0] r_pc;

    // Additions are modulo 2^D so the top address rolls over to 0.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc <= '0;
        end else if (branch) begin
            r_pc <= target;
        end else if (rel_jump) begin
            r_pc <= r_pc + rel_offset;
        end else begin
            r_pc <= r_pc + D'(1);
        end
    end

    assign prog_ctr = r_pc;

endmodule : pc_reg
`default_nettype wire

// File: rtl/pc_control.sv
`default_nettype none
// ============================================================================
// Module      : pc_control
// Description : Accumulator-machine instruction decode, jump table and PC.
//               Define PC_RELJUMP_EN to let JMP with instr[4]=1 jump relative.
// Revision    : 1.0
// ============================================================================
module pc_control
    import pc_control_pkg::*;
#(
    parameter int D   = C_D_DEFAULT,
    parameter int OPW = C_OPW_DEFAULT
) (
    input  wire logic   clk,
    input  wire logic   reset,
    pc_control_if.slave bus
);

    opcode_t        w_opcode;
    logic           w_branch;
    logic           w_memtoreg;
    logic           w_memwrite;
    logic           w_alusrc;
    logic           w_regwrite;
    logic [3:0]     w_rega;
    logic [3:0]     w_regb;
    logic [3:0]     w_wr_addr;
    logic [7:0]     w_dat_in;
    logic [7:0]     w_mem_in;
    logic [7:0]     w_mem_addr;
    logic [4:0]     w_immed;
    logic [3:0]     w_pc_immed;
    logic [OPW-1:0] w_aluop;
    logic           w_rel_jump;
    logic [D-1:0]   w_rel_offset;
    logic [D-1:0]   w_target;
    logic [D-1:0]   w_prog_ctr;

    assign w_opcode = opcode_t'(bus.instr[8:5]);

    always_comb begin
        w_branch     = 1'b0;
        w_memtoreg   = 1'b0;
        w_memwrite   = 1'b0;
        w_alusrc     = 1'b0;
        w_regwrite   = 1'b0;
        w_rega       = 4'd0;
        w_regb       = bus.instr[3:0];
        w_wr_addr    = 4'd0;
        w_immed      = bus.instr[4:0];
        w_pc_immed   = bus.instr[3:0];
        w_aluop      = OPW'(bus.instr[8:5]);
        w_dat_in     = bus.alu_rslt;
        w_mem_in     = bus.datA;
        w_mem_addr   = bus.datB;
        w_rel_jump   = 1'b0;
        w_rel_offset = {{(D-4){bus.instr[3]}}, bus.instr[3:0]};

        case (w_opcode)
            OP_ALU0, OP_ALU1, OP_ALU2, OP_ALU3,
            OP_ALU4, OP_ALU5, OP_ALU6, OP_ALU7: begin
                w_regwrite = 1'b1;
            end
            OP_MOVTO: begin
                w_wr_addr  = bus.instr[3:0];
                w_dat_in   = bus.datA;
                w_regwrite = 1'b1;
            end
            OP_MOVFROM: begin
                w_dat_in   = bus.datB;
                w_regwrite = 1'b1;
            end
            OP_ADDI: begin
                w_aluop    = '0;
                w_alusrc   = 1'b1;
                w_regwrite = 1'b1;
            end
            OP_LD: begin
                w_dat_in   = bus.mem_out;
                w_memtoreg = 1'b1;
                w_regwrite = 1'b1;
            end
            OP_ST: begin
                w_memwrite = 1'b1;
            end
            OP_LDC: begin
                w_dat_in   = bus.mem_lut_out;
                w_regwrite = 1'b1;
            end
            OP_BZ: begin
                w_branch = (bus.datA == 8'h00);
            end
            OP_JMP: begin
`ifdef PC_RELJUMP_EN
                if (bus.instr[4]) begin
                    w_rel_jump = 1'b1;
                end else begin
                    w_branch = 1'b1;
                end
`else
                w_branch = 1'b1;
`endif
            end
            default: ;
        endcase
    end

    assign w_target = D'(c_jump_table[w_pc_immed]);

    pc_reg #(
        .D (D)
    ) u_pc_reg (
        .clk        (clk),
        .reset      (reset),
        .branch     (w_branch),
        .target     (w_target),
        .rel_jump   (w_rel_jump),
        .rel_offset (w_rel_offset),
        .prog_ctr   (w_prog_ctr)
    );

    assign bus.prog_ctr = w_prog_ctr;
    assign bus.Branch   = w_branch;
    assign bus.MemtoReg = w_memtoreg;
    assign bus.MemWrite = w_memwrite;
    assign bus.ALUSrc   = w_alusrc;
    assign bus.RegWrite = w_regwrite;
    assign bus.regA     = w_rega;
    assign bus.regB     = w_regb;
    assign bus.wr_addr  = w_wr_addr;
    assign bus.dat_in   = w_dat_in;
    assign bus.mem_in   = w_mem_in;
    assign bus.mem_addr = w_mem_addr;
    assign bus.immed    = w_immed;
    assign bus.pc_immed = w_pc_immed;
    assign bus.ALUOp    = w_aluop;

endmodule : pc_control
`default_nettype wire

// File: tb/tb_pc_control.sv
`default_nettype none
// ============================================================================
// Module      : tb_pc_control
// Description : Directed self-checking bench for pc_control (decode and PC).
// Revision    : 1.0
// ============================================================================
module tb_pc_control;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_fail;

    pc_control_if #(.D(10), .OPW(4)) bus ();

    pc_control #(.D(10), .OPW(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle just past it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_checks        = 0;
        n_fail          = 0;
        reset           = 1'b1;
        bus.instr       = 9'h000;
        bus.datA        = 8'h00;
        bus.datB        = 8'h00;
        bus.mem_out     = 8'hC3;
        bus.mem_lut_out = 8'h3C;
        bus.alu_rslt    = 8'h77;

        step();
        step();
        reset = 1'b0;
        check_value("reset_pc", 32'(bus.prog_ctr), 32'd0);
        for (int i = 1; i <= 5; i++) begin
            step();
            check_value($sformatf("count_%0d", i), 32'(bus.prog_ctr), 32'(i));
        end

        // Absolute JMP through entry 3
        bus.instr = 9'h1E3;
        #1;
        check_value("jmp_branch", 32'(bus.Branch), 32'd1);
        check_value("jmp_regwrite", 32'(bus.RegWrite), 32'd0);
        step();
        check_value("jmp_pc", 32'(bus.prog_ctr), 32'd24);

        // BZ taken / not taken, entry 2
        bus.instr = 9'h1C2;
        bus.datA  = 8'h00;
        #1;
        check_value("bz_taken_branch", 32'(bus.Branch), 32'd1);
        step();
        check_value("bz_taken_pc", 32'(bus.prog_ctr), 32'd16);
        bus.datA = 8'h05;
        #1;
        check_value("bz_not_taken_branch", 32'(bus.Branch), 32'd0);
        step();
        check_value("bz_not_taken_pc", 32'(bus.prog_ctr), 32'd17);

        // ST r4
        bus.instr = 9'h184;
        bus.datA  = 8'h5A;
        bus.datB  = 8'h10;
        #1;
        check_value("st_memwrite", 32'(bus.MemWrite), 32'd1);
        check_value("st_mem_in", 32'(bus.mem_in), 32'h5A);
        check_value("st_mem_addr", 32'(bus.mem_addr), 32'h10);
        check_value("st_regwrite", 32'(bus.RegWrite), 32'd0);
        check_value("st_regb", 32'(bus.regB), 32'd4);

        // MOVTO r3
        bus.instr = 9'h103;
        #1;
        check_value("movto_wr_addr", 32'(bus.wr_addr), 32'd3);
        check_value("movto_dat_in", 32'(bus.dat_in), 32'h5A);
        check_value("movto_regwrite", 32'(bus.RegWrite), 32'd1);

        // MOVFROM r5
        bus.instr = 9'h125;
        #1;
        check_value("movfrom_dat_in", 32'(bus.dat_in), 32'h10);
        check_value("movfrom_wr_addr", 32'(bus.wr_addr), 32'd0);

        // ADDI #7
        bus.instr = 9'h147;
        #1;
        check_value("addi_aluop", 32'(bus.ALUOp), 32'd0);
        check_value("addi_alusrc", 32'(bus.ALUSrc), 32'd1);
        check_value("addi_immed", 32'(bus.immed), 32'd7);
        check_value("addi_dat_in", 32'(bus.dat_in), 32'h77);

        // LD
        bus.instr = 9'h160;
        #1;
        check_value("ld_dat_in", 32'(bus.dat_in), 32'hC3);
        check_value("ld_memtoreg", 32'(bus.MemtoReg), 32'd1);

        // LDC #9
        bus.instr = 9'h1A9;
        #1;
        check_value("ldc_dat_in", 32'(bus.dat_in), 32'h3C);
        check_value("ldc_immed", 32'(bus.immed), 32'd9);

        // ALU op 3 with r5
        bus.instr = 9'h065;
        #1;
        check_value("alu_aluop", 32'(bus.ALUOp), 32'd3);
        check_value("alu_regb", 32'(bus.regB), 32'd5);
        check_value("alu_rega", 32'(bus.regA), 32'd0);
        check_value("alu_regwrite", 32'(bus.RegWrite), 32'd1);
        check_value("alu_dat_in", 32'(bus.dat_in), 32'h77);
        check_value("alu_branch", 32'(bus.Branch), 32'd0);

        // Count up to the top address, then wrap
        for (int i = 0; i < 1100 && bus.prog_ctr != 10'd1023; i++) begin
            step();
        end
        check_value("reach_1023", 32'(bus.prog_ctr), 32'd1023);
        step();
        check_value("wrap_pc", 32'(bus.prog_ctr), 32'd0);

        // Jump to current address holds the PC
        bus.instr = 9'h1E0;
        step();
        check_value("hold_pc_0", 32'(bus.prog_ctr), 32'd0);
        step();
        check_value("hold_pc_1", 32'(bus.prog_ctr), 32'd0);

        // Reset beats a simultaneous JMP and discards it
        bus.instr = 9'h000;
        step();
        step();
        check_value("pre_reset_pc", 32'(bus.prog_ctr), 32'd2);
        bus.instr = 9'h1E3;
        reset     = 1'b1;
        step();
        check_value("reset_jmp_pc", 32'(bus.prog_ctr), 32'd0);
        reset     = 1'b0;
        bus.instr = 9'h000;
        step();
        check_value("post_reset_pc", 32'(bus.prog_ctr), 32'd1);

        // JMP with instr[4]=1 from address 40
        bus.instr = 9'h1E5;
        step();
        check_value("jmp_to_40", 32'(bus.prog_ctr), 32'd40);
        bus.instr = 9'h1FE;
        #1;
`ifdef PC_RELJUMP_EN
        check_value("reljmp_branch", 32'(bus.Branch), 32'd0);
        step();
        check_value("reljmp_pc", 32'(bus.prog_ctr), 32'd38);
`else
        check_value("jmp_bit4_branch", 32'(bus.Branch), 32'd1);
        step();
        check_value("jmp_bit4_pc", 32'(bus.prog_ctr), 32'd112);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_pc_control
`default_nettype wire
